// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants and types for the frame-buffer RAM port arbiter.
//   DEPTH_DEFAULT : word count of the 8x320x320 frame buffer
//   rd_tag_t      : per-read-port return tag {valid, requester id}
package ram_arb_pkg;

    localparam longint unsigned DEPTH_DEFAULT = 64'(8 * 320 * 320);

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } rd_tag_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: round-robin picker returning the first two eligible requesters.
//   i_req  : request vector (bits >= N must be zero)
//   i_mask : eligibility for the second pick only
//   i_ptr  : scan start index, 0..N-1
//   o_v0/o_i0 : first hit from i_ptr, wrapping
//   o_v1/o_i1 : next hit after the first that is also allowed by i_mask
module rr_pick2 #(
    parameter int N = 4
) (
    input  logic [7:0] i_req,
    input  logic [7:0] i_mask,
    input  logic [2:0] i_ptr,
    output logic       o_v0,
    output logic [2:0] o_i0,
    output logic       o_v1,
    output logic [2:0] o_i1
);

    logic w_seen;

    function automatic logic [2:0] slot(input logic [2:0] p, input int k);
        return 3'((int'(p) + k) % N);
    endfunction

    always_comb begin
        o_v0 = 1'b0;
        o_i0 = '0;
        for (int k = 0; k < N; k++) begin
            if (!o_v0 && i_req[slot(i_ptr, k)]) begin
                o_v0 = 1'b1;
                o_i0 = slot(i_ptr, k);
            end
        end
    end

    // The first hit is re-found here rather than read from o_i0 so the
    // second pick only depends on the mask, which itself depends on o_i0.
    always_comb begin
        o_v1   = 1'b0;
        o_i1   = '0;
        w_seen = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (i_req[slot(i_ptr, k)]) begin
                if (!w_seen) begin
                    w_seen = 1'b1;
                end else if (!o_v1 && i_mask[slot(i_ptr, k)]) begin
                    o_v1 = 1'b1;
                    o_i1 = slot(i_ptr, k);
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares a 2-write/2-read-port frame-buffer RAM among NREQ requesters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req/we/addr/wdata   : per-requester request, direction, word address, write data
//   gnt                 : combinational accept (request completes when req & gnt)
//   err                 : one-cycle pulse after a granted out-of-range request
//   rvalid/rdata        : read return, one cycle after grant, routed to the issuer
//   ram_*               : RAM port enables, addresses, write data and read data
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int              NREQ  = 4,
    parameter int              AW    = 32,
    parameter int              DW    = 32,
    parameter longint unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    err,
    output logic [NREQ-1:0]    rvalid,
    output logic [NREQ*DW-1:0] rdata,
    output logic               ram_write0,
    output logic               ram_write1,
    output logic               ram_read0,
    output logic               ram_read1,
    output logic [AW-1:0]      ram_addr_wr0,
    output logic [AW-1:0]      ram_addr_wr1,
    output logic [AW-1:0]      ram_addr_rd0,
    output logic [AW-1:0]      ram_addr_rd1,
    output logic [DW-1:0]      ram_datain0,
    output logic [DW-1:0]      ram_datain1,
    input  logic [DW-1:0]      ram_dataout0,
    input  logic [DW-1:0]      ram_dataout1
);

    logic [AW-1:0] w_addr  [8];
    logic [DW-1:0] w_wdata [8];
    logic [7:0]    w_oor;
    logic [7:0]    w_wreq;
    logic [7:0]    w_rreq;
    logic [7:0]    w_wmask;
    logic          w_wv0, w_wv1, w_rv0, w_rv1;
    logic [2:0]    w_wi0, w_wi1, w_ri0, w_ri1;
    logic [2:0]    r_rr_wr, r_rr_rd;
    logic [NREQ-1:0] r_err;
    rd_tag_t       r_tag0, r_tag1;

    // Requests are masked by reset so gnt and every RAM enable stay low
    // while rst_n is asserted. Slots beyond NREQ are tied off.
    for (genvar i = 0; i < 8; i++) begin : g_slot
        if (i < NREQ) begin : g_act
            assign w_addr[i]  = addr[i*AW +: AW];
            assign w_wdata[i] = wdata[i*DW +: DW];
            assign w_oor[i]   = 64'(w_addr[i]) >= DEPTH;
            assign w_wreq[i]  = rst_n & req[i] & we[i];
            assign w_rreq[i]  = rst_n & req[i] & ~we[i];
            assign w_wmask[i] = w_addr[i] != w_addr[w_wi0];
        end else begin : g_pad
            assign w_addr[i]  = '0;
            assign w_wdata[i] = '0;
            assign w_oor[i]   = 1'b0;
            assign w_wreq[i]  = 1'b0;
            assign w_rreq[i]  = 1'b0;
            assign w_wmask[i] = 1'b0;
        end
    end

    // Write port 1 may not target the same word as write port 0: the RAM
    // does not resolve that, so a colliding requester is skipped.
    rr_pick2 #(.N(NREQ)) u_pick_wr (
        .i_req  (w_wreq),
        .i_mask (w_wmask),
        .i_ptr  (r_rr_wr),
        .o_v0   (w_wv0),
        .o_i0   (w_wi0),
        .o_v1   (w_wv1),
        .o_i1   (w_wi1)
    );

    rr_pick2 #(.N(NREQ)) u_pick_rd (
        .i_req  (w_rreq),
        .i_mask (8'hFF),
        .i_ptr  (r_rr_rd),
        .o_v0   (w_rv0),
        .o_i0   (w_ri0),
        .o_v1   (w_rv1),
        .o_i1   (w_ri1)
    );

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = (w_wv0 && w_wi0 == 3'(i)) || (w_wv1 && w_wi1 == 3'(i)) ||
                     (w_rv0 && w_ri0 == 3'(i)) || (w_rv1 && w_ri1 == 3'(i));
        end
    end

    // Out-of-range requests are granted but never reach the RAM.
    assign ram_write0   = w_wv0 & ~w_oor[w_wi0];
    assign ram_write1   = w_wv1 & ~w_oor[w_wi1];
    assign ram_read0    = w_rv0 & ~w_oor[w_ri0];
    assign ram_read1    = w_rv1 & ~w_oor[w_ri1];
    assign ram_addr_wr0 = w_addr[w_wi0];
    assign ram_addr_wr1 = w_addr[w_wi1];
    assign ram_addr_rd0 = w_addr[w_ri0];
    assign ram_addr_rd1 = w_addr[w_ri1];
    assign ram_datain0  = w_wdata[w_wi0];
    assign ram_datain1  = w_wdata[w_wi1];

    function automatic logic [2:0] nxt(input logic [2:0] i);
        return (i == 3'(NREQ - 1)) ? 3'd0 : i + 3'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_wr <= '0;
            r_rr_rd <= '0;
            r_err   <= '0;
            r_tag0  <= '0;
            r_tag1  <= '0;
        end else begin
            r_rr_wr <= w_wv1 ? nxt(w_wi1) : w_wv0 ? nxt(w_wi0) : r_rr_wr;
            r_rr_rd <= w_rv1 ? nxt(w_ri1) : w_rv0 ? nxt(w_ri0) : r_rr_rd;
            r_err   <= gnt & w_oor[NREQ-1:0];
            r_tag0  <= '{valid: ram_read0, id: w_ri0};
            r_tag1  <= '{valid: ram_read1, id: w_ri1};
        end
    end

    assign err = r_err;

    // The two read tags always name different requesters, so at most one
    // RAM output is steered onto any given rdata lane.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int i = 0; i < NREQ; i++) begin
            rvalid[i] = (r_tag0.valid && r_tag0.id == 3'(i)) ||
                        (r_tag1.valid && r_tag1.id == 3'(i));
            rdata[i*DW +: DW] = (r_tag0.valid && r_tag0.id == 3'(i)) ? ram_dataout0 :
                                (r_tag1.valid && r_tag1.id == 3'(i)) ? ram_dataout1 : '0;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and randomized check of ram_port_arbiter against a behavioural model.
module tb_ram_port_arbiter;

    localparam int              NREQ  = 4;
    localparam int              AW    = 32;
    localparam int              DW    = 32;
    localparam longint unsigned DEPTH = 819200;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    we = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0]    gnt, err, rvalid;
    logic [NREQ*DW-1:0] rdata;
    logic               ram_write0, ram_write1, ram_read0, ram_read1;
    logic [AW-1:0]      ram_addr_wr0, ram_addr_wr1, ram_addr_rd0, ram_addr_rd1;
    logic [DW-1:0]      ram_datain0, ram_datain1;
    logic [DW-1:0]      ram_dataout0, ram_dataout1;

    always #5 clk = ~clk;

    ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .err          (err),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .ram_write0   (ram_write0),
        .ram_write1   (ram_write1),
        .ram_read0    (ram_read0),
        .ram_read1    (ram_read1),
        .ram_addr_wr0 (ram_addr_wr0),
        .ram_addr_wr1 (ram_addr_wr1),
        .ram_addr_rd0 (ram_addr_rd0),
        .ram_addr_rd1 (ram_addr_rd1),
        .ram_datain0  (ram_datain0),
        .ram_datain1  (ram_datain1),
        .ram_dataout0 (ram_dataout0),
        .ram_dataout1 (ram_dataout1)
    );

    // Bench-side RAM: registered read-before-write, only low addresses are used.
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < 256; j++) ram[j] <= '0;
        end else begin
            if (ram_read0)  ram_dataout0 <= ram[ram_addr_rd0[7:0]];
            if (ram_read1)  ram_dataout1 <= ram[ram_addr_rd1[7:0]];
            if (ram_write0) ram[ram_addr_wr0[7:0]] <= ram_datain0;
            if (ram_write1) ram[ram_addr_wr1[7:0]] <= ram_datain1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int pw, pr;
    logic [NREQ-1:0]    exp_gnt, exp_err, exp_rvalid, gnt_seen;
    logic [NREQ*DW-1:0] exp_rdata;
    logic [DW-1:0]      exp_mem [256];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] a_of(input int i);
        return addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] d_of(input int i);
        return wdata[i*DW +: DW];
    endfunction

    function automatic bit inr(input int i);
        return (i >= 0) && (64'(a_of(i)) < DEPTH);
    endfunction

    // Reference: scan from the pointer, first two hits per direction, a second
    // write to port 0's address is passed over; then apply RAM semantics.
    task automatic model_cycle();
        int pick [4];
        logic [3:0] en;
        logic [AW-1:0] ad;
        pick = '{-1, -1, -1, -1};
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (pw + k) % NREQ;
            if (req[i] && we[i]) begin
                if (pick[0] < 0) pick[0] = i;
                else if (pick[1] < 0 && a_of(i) != a_of(pick[0])) pick[1] = i;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (pr + k) % NREQ;
            if (req[i] && !we[i]) begin
                if (pick[2] < 0) pick[2] = i;
                else if (pick[3] < 0) pick[3] = i;
            end
        end
        exp_gnt = '0;
        for (int j = 0; j < 4; j++) if (pick[j] >= 0) exp_gnt[pick[j]] = 1'b1;
        gnt_seen = gnt;
        chk("gnt", gnt, exp_gnt);
        for (int j = 0; j < 4; j++) en[3-j] = inr(pick[j]);
        chk("ram_en", {ram_write0, ram_write1, ram_read0, ram_read1}, en);
        if (en[3]) chk("wr0", {ram_addr_wr0, ram_datain0}, {a_of(pick[0]), d_of(pick[0])});
        if (en[2]) chk("wr1", {ram_addr_wr1, ram_datain1}, {a_of(pick[1]), d_of(pick[1])});
        if (en[1]) chk("rd0_addr", ram_addr_rd0, a_of(pick[2]));
        if (en[0]) chk("rd1_addr", ram_addr_rd1, a_of(pick[3]));
        exp_err = '0;
        exp_rvalid = '0;
        exp_rdata = '0;
        for (int j = 0; j < 4; j++) begin
            if (pick[j] >= 0 && !inr(pick[j])) exp_err[pick[j]] = 1'b1;
        end
        for (int j = 2; j < 4; j++) begin
            if (inr(pick[j])) begin
                ad = a_of(pick[j]);
                exp_rvalid[pick[j]] = 1'b1;
                exp_rdata[pick[j]*DW +: DW] = exp_mem[ad[7:0]];
            end
        end
        for (int j = 0; j < 2; j++) begin
            if (inr(pick[j])) begin
                ad = a_of(pick[j]);
                exp_mem[ad[7:0]] = d_of(pick[j]);
            end
        end
        if (pick[1] >= 0) pw = (pick[1] + 1) % NREQ;
        else if (pick[0] >= 0) pw = (pick[0] + 1) % NREQ;
        if (pick[3] >= 0) pr = (pick[3] + 1) % NREQ;
        else if (pick[2] >= 0) pr = (pick[2] + 1) % NREQ;
    endtask

    // Called with inputs set after a falling edge; returns at the next falling edge.
    task automatic tick();
        #1 model_cycle();
        @(posedge clk);
        @(negedge clk);
        chk("err", err, exp_err);
        chk("rvalid", rvalid, exp_rvalid);
        chk("rdata", rdata, exp_rdata);
        req &= ~exp_gnt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '1;
        we = NREQ'($urandom);
        #1;
        chk("rst_gnt", gnt, '0);
        chk("rst_en", {ram_write0, ram_write1, ram_read0, ram_read1}, '0);
        chk("rst_rvalid", rvalid, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt_held", gnt, '0);
        pw = 0;
        pr = 0;
        exp_err = '0;
        exp_rvalid = '0;
        exp_rdata = '0;
        for (int j = 0; j < 256; j++) exp_mem[j] = '0;
        rst_n = 1'b1;
        req = '0;
        #1;
        chk("rst_err", err, '0);
        chk("rst_rdata", rdata, '0);
    endtask

    task automatic set_rq(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        we[i] = w;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    initial begin
        do_reset();

        for (int i = 0; i < NREQ; i++) set_rq(i, 1'b1, AW'(10 + i), DW'(32'h1000 + i));
        tick();
        chk("4w_c1_gnt", gnt_seen, 4'b0011);
        tick();
        chk("4w_c2_gnt", gnt_seen, 4'b1100);
        for (int i = 0; i < NREQ; i++) set_rq(i, 1'b0, AW'(10 + i), '0);
        tick();
        chk("4w_rd0", rdata[0*DW +: DW], 32'h1000);
        chk("4w_rd1", rdata[1*DW +: DW], 32'h1001);
        tick();
        chk("4w_rd2", rdata[2*DW +: DW], 32'h1002);
        chk("4w_rd3", rdata[3*DW +: DW], 32'h1003);

        set_rq(0, 1'b1, 100, 32'hA);
        set_rq(1, 1'b1, 100, 32'hB);
        tick();
        chk("coll_c1_gnt", gnt_seen, 4'b0001);
        tick();
        chk("coll_c2_gnt", gnt_seen, 4'b0010);
        set_rq(0, 1'b0, 100, '0);
        tick();
        chk("coll_rd", rdata[0*DW +: DW], 32'hB);

        set_rq(0, 1'b1, 5, 32'h55);
        set_rq(1, 1'b1, 6, 32'h66);
        tick();
        set_rq(1, 1'b0, 5, '0);
        set_rq(3, 1'b0, 6, '0);
        tick();
        chk("route_rvalid", rvalid, 4'b1010);
        chk("route_rd1", rdata[1*DW +: DW], 32'h55);
        chk("route_rd3", rdata[3*DW +: DW], 32'h66);

        set_rq(2, 1'b0, AW'(DEPTH), '0);
        #1;
        chk("oor_gnt", gnt[2], 1'b1);
        chk("oor_rden", {ram_read0, ram_read1}, 2'b00);
        tick();
        chk("oor_err", err[2], 1'b1);
        chk("oor_rvalid", rvalid[2], 1'b0);

        set_rq(0, 1'b1, 7, 32'h11);
        tick();
        set_rq(0, 1'b1, 7, 32'h77);
        set_rq(1, 1'b0, 7, '0);
        tick();
        chk("rbw_old", rdata[1*DW +: DW], 32'h11);
        set_rq(1, 1'b0, 7, '0);
        tick();
        chk("rbw_new", rdata[1*DW +: DW], 32'h77);

        set_rq(0, 1'b0, 5, '0);
        #1 model_cycle();
        @(posedge clk);
        #2;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_rq(i, 1'b1, AW'(20 + i), DW'(i));
        tick();
        chk("post_rst_gnt", gnt_seen, 4'b0011);
        req = '0;

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_rq(i, 1'($urandom_range(0, 1)),
                               ($urandom_range(0, 11) == 0) ? AW'(DEPTH + 64'($urandom_range(0, 2)))
                                                            : AW'($urandom_range(0, 7)),
                               DW'($urandom));
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            tick();
        end

        req = '0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
